// File: rtl/if_id_pipe.sv
// if_id_pipe: IF/ID pipeline stage with a 2-entry skid buffer.
// Valid/ready handshakes on the fetch and decode sides, flush and fetch-error tagging.
// When no valid instruction is held, decode sees NOP.
// Optional performance counters are enabled by defining IF_ID_PERF_EN.
// Entry A drives the outputs. Entry S catches one instruction while decode stalls.
module if_id_pipe #(
    parameter int          ADDR_W   = 32,
    parameter int          INST_W   = 32,
    parameter logic [INST_W-1:0] NOP_VAL  = 32'h0000_0013,
    parameter logic [ADDR_W-1:0] RST_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [INST_W-1:0] inst_i,
    input  logic [ADDR_W-1:0] inst_addr_i,
    input  logic              inst_err_i,
    input  logic              flush_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [INST_W-1:0] inst_o,
    output logic [ADDR_W-1:0] inst_addr_o,
`ifdef IF_ID_PERF_EN
    output logic              inst_err_o,
    output logic [31:0]       stall_cnt_o,
    output logic [31:0]       bubble_cnt_o
`else
    output logic              inst_err_o
`endif
);

    // Output entry A. The instruction field holds NOP_VAL and the error field is 0
    // whenever A is empty, so the outputs come straight from flops.
    logic              r_a_valid;
    logic [INST_W-1:0] r_a_inst;
    logic [ADDR_W-1:0] r_a_addr;
    logic              r_a_err;

    // Skid entry S.
    logic              r_s_valid;
    logic [INST_W-1:0] r_s_inst;
    logic [ADDR_W-1:0] r_s_addr;
    logic              r_s_err;

    logic              r_in_ready;

    // Next-state values.
    logic              w_a_valid;
    logic [INST_W-1:0] w_a_inst;
    logic [ADDR_W-1:0] w_a_addr;
    logic              w_a_err;
    logic              w_s_valid;
    logic [INST_W-1:0] w_s_inst;
    logic [ADDR_W-1:0] w_s_addr;
    logic              w_s_err;

    logic              w_accept;
    logic              w_take;

    assign w_accept = in_valid_i & r_in_ready & ~flush_i;
    assign w_take   = r_a_valid & out_ready_i;

    // Next-state selection: flush, then refill A, then skid, then hold.
    always_comb begin
        w_a_valid = r_a_valid;
        w_a_inst  = r_a_inst;
        w_a_addr  = r_a_addr;
        w_a_err   = r_a_err;
        w_s_valid = r_s_valid;
        w_s_inst  = r_s_inst;
        w_s_addr  = r_s_addr;
        w_s_err   = r_s_err;
        if (flush_i) begin
            w_a_valid = 1'b0;
            w_a_inst  = NOP_VAL;
            w_a_addr  = RST_ADDR;
            w_a_err   = 1'b0;
            w_s_valid = 1'b0;
        end else if (!r_a_valid || w_take) begin
            if (r_s_valid) begin
                // S is full, so in_ready was low and no accept can occur this cycle.
                w_a_valid = 1'b1;
                w_a_inst  = r_s_inst;
                w_a_addr  = r_s_addr;
                w_a_err   = r_s_err;
                w_s_valid = 1'b0;
            end else if (w_accept) begin
                w_a_valid = 1'b1;
                w_a_inst  = inst_i;
                w_a_addr  = inst_addr_i;
                w_a_err   = inst_err_i;
            end else begin
                // Going empty. Keep the last PC and present NOP with a clear error tag.
                w_a_valid = 1'b0;
                w_a_inst  = NOP_VAL;
                w_a_err   = 1'b0;
            end
        end else if (w_accept) begin
            w_s_valid = 1'b1;
            w_s_inst  = inst_i;
            w_s_addr  = inst_addr_i;
            w_s_err   = inst_err_i;
        end else begin
            w_s_valid = r_s_valid;
        end
    end

    // Register both entries and in_ready. in_ready is derived from the next S state only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_valid  <= 1'b0;
            r_a_inst   <= NOP_VAL;
            r_a_addr   <= RST_ADDR;
            r_a_err    <= 1'b0;
            r_s_valid  <= 1'b0;
            r_s_inst   <= NOP_VAL;
            r_s_addr   <= RST_ADDR;
            r_s_err    <= 1'b0;
            r_in_ready <= 1'b1;
        end else begin
            r_a_valid  <= w_a_valid;
            r_a_inst   <= w_a_inst;
            r_a_addr   <= w_a_addr;
            r_a_err    <= w_a_err;
            r_s_valid  <= w_s_valid;
            r_s_inst   <= w_s_inst;
            r_s_addr   <= w_s_addr;
            r_s_err    <= w_s_err;
            r_in_ready <= ~w_s_valid;
        end
    end

    assign in_ready_o  = r_in_ready;
    assign out_valid_o = r_a_valid;
    assign inst_o      = r_a_inst;
    assign inst_addr_o = r_a_addr;
    assign inst_err_o  = r_a_err;

`ifdef IF_ID_PERF_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_bubble_cnt;

    // Count stalled and empty cycles. Only rst_n clears the counters, and they wrap freely.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt  <= 32'd0;
            r_bubble_cnt <= 32'd0;
        end else begin
            if (r_a_valid && !out_ready_i) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end else begin
                r_stall_cnt <= r_stall_cnt;
            end
            if (!r_a_valid && !flush_i) begin
                r_bubble_cnt <= r_bubble_cnt + 32'd1;
            end else begin
                r_bubble_cnt <= r_bubble_cnt;
            end
        end
    end

    assign stall_cnt_o  = r_stall_cnt;
    assign bubble_cnt_o = r_bubble_cnt;
`endif

endmodule

// File: tb/tb_if_id_pipe.sv
// Testbench for if_id_pipe.
// A scoreboard queue models the two-entry stage. Each accept pushes onto it, and each take pops from it.
// Every cycle, the outputs are compared against the head of the queue.
module tb_if_id_pipe;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [31:0] inst_i;
    logic [31:0] inst_addr_i;
    logic        inst_err_i;
    logic        flush_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] inst_o;
    logic [31:0] inst_addr_o;
    logic        inst_err_o;
`ifdef IF_ID_PERF_EN
    logic [31:0] stall_cnt_o;
    logic [31:0] bubble_cnt_o;
    int unsigned m_stall;
    int unsigned m_bubble;
`endif

    if_id_pipe dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid_i (in_valid_i),
        .in_ready_o (in_ready_o),
        .inst_i     (inst_i),
        .inst_addr_i(inst_addr_i),
        .inst_err_i (inst_err_i),
        .flush_i    (flush_i),
        .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i),
        .inst_o     (inst_o),
        .inst_addr_o(inst_addr_o),
`ifdef IF_ID_PERF_EN
        .inst_err_o (inst_err_o),
        .stall_cnt_o(stall_cnt_o),
        .bubble_cnt_o(bubble_cnt_o)
`else
        .inst_err_o (inst_err_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] addr;
        logic        err;
    } entry_t;

    entry_t      q[$];
    logic [31:0] last_addr;
    int          errors;
    int          checks;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Compare the DUT outputs against the scoreboard state.
    task automatic check_outputs();
        chk("in_ready", {31'd0, in_ready_o}, {31'd0, (q.size() < 2)});
        chk("out_valid", {31'd0, out_valid_o}, {31'd0, (q.size() > 0)});
        if (q.size() > 0) begin
            chk("inst", inst_o, q[0].inst);
            chk("addr", inst_addr_o, q[0].addr);
            chk("err", {31'd0, inst_err_o}, {31'd0, q[0].err});
        end else begin
            chk("inst_nop", inst_o, NOP);
            chk("addr_last", inst_addr_o, last_addr);
            chk("err_empty", {31'd0, inst_err_o}, 32'd0);
        end
`ifdef IF_ID_PERF_EN
        chk("stall_cnt", stall_cnt_o, m_stall);
        chk("bubble_cnt", bubble_cnt_o, m_bubble);
`endif
    endtask

    // Check the outputs, clock once, and advance the model using the inputs held across the edge.
    task automatic cycle();
        bit take;
        bit acc;
        check_outputs();
        take = (q.size() > 0) && out_ready_i;
        acc  = in_valid_i && (q.size() < 2) && !flush_i;
`ifdef IF_ID_PERF_EN
        if ((q.size() > 0) && !out_ready_i) m_stall++;
        if ((q.size() == 0) && !flush_i) m_bubble++;
`endif
        @(posedge clk);
        if (flush_i) begin
            q.delete();
            last_addr = 32'd0;
        end else begin
            if (take) void'(q.pop_front());
            if (acc) q.push_back('{inst: inst_i, addr: inst_addr_i, err: inst_err_i});
            if (q.size() > 0) last_addr = q[0].addr;
        end
        #1;
    endtask

    task automatic drive(input bit v, input logic [31:0] a, input logic [31:0] d,
                         input bit e, input bit rdy, input bit fl);
        in_valid_i  = v;
        inst_addr_i = a;
        inst_i      = d;
        inst_err_i  = e;
        out_ready_i = rdy;
        flush_i     = fl;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        last_addr = 32'd0;
`ifdef IF_ID_PERF_EN
        m_stall = 0;
        m_bubble = 0;
`endif
        rst_n = 1'b0;
        drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0);
        #12;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: idle after reset
        cycle();
        cycle();

        // 2: stream three instructions with decode always ready
        drive(1'b1, 32'h0, 32'hA, 1'b0, 1'b1, 1'b0); cycle();
        drive(1'b1, 32'h4, 32'hB, 1'b1, 1'b1, 1'b0); cycle();
        drive(1'b1, 32'h8, 32'hC, 1'b0, 1'b1, 1'b0); cycle();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0); cycle();
        cycle();

        // 3: stall with skid capture, then release
        drive(1'b1, 32'h0, 32'hA, 1'b0, 1'b1, 1'b0); cycle();
        drive(1'b1, 32'h4, 32'hB, 1'b0, 1'b0, 1'b0); cycle();
        drive(1'b1, 32'h8, 32'hC, 1'b0, 1'b0, 1'b0); cycle();
        cycle();
        chk("skid_full", {31'd0, in_ready_o}, 32'd0);
        chk("stall_addr", inst_addr_o, 32'h0);
        chk("stall_inst", inst_o, 32'hA);
        drive(1'b1, 32'h8, 32'hC, 1'b0, 1'b1, 1'b0); cycle();
        cycle();
        cycle();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0); cycle();
        cycle();

        // 4: fill both entries, then flush while PC 0x10 is offered
        drive(1'b1, 32'h20, 32'h20, 1'b0, 1'b0, 1'b0); cycle();
        drive(1'b1, 32'h24, 32'h24, 1'b1, 1'b0, 1'b0); cycle();
        drive(1'b1, 32'h10, 32'h10, 1'b0, 1'b1, 1'b1); cycle();
        chk("flush_valid", {31'd0, out_valid_o}, 32'd0);
        chk("flush_addr", inst_addr_o, 32'd0);
        chk("flush_ready", {31'd0, in_ready_o}, 32'd1);
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0); cycle();
        cycle();

        // 5: asynchronous reset in the middle of a stall
        drive(1'b1, 32'h40, 32'h40, 1'b0, 1'b0, 1'b0); cycle();
        drive(1'b1, 32'h44, 32'h44, 1'b0, 1'b0, 1'b0); cycle();
        cycle();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", {31'd0, out_valid_o}, 32'd0);
        chk("arst_inst", inst_o, NOP);
        chk("arst_addr", inst_addr_o, 32'd0);
        chk("arst_ready", {31'd0, in_ready_o}, 32'd1);
        q.delete();
        last_addr = 32'd0;
`ifdef IF_ID_PERF_EN
        m_stall = 0;
        m_bubble = 0;
`endif
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cycle();

        // 6: counter check with 5 stall cycles then 2 empty cycles (model-checked when enabled)
        drive(1'b1, 32'h50, 32'h50, 1'b0, 1'b0, 1'b0); cycle();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) cycle();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0); cycle();
        cycle();
        cycle();

        // Random traffic with occasional flushes
        for (int i = 0; i < 60; i++) begin
            drive($urandom_range(0, 3) != 0, 32'h100 + 32'(i * 4), 32'h1000 + 32'(i),
                  $urandom_range(0, 3) == 0, $urandom_range(0, 2) != 0,
                  $urandom_range(0, 15) == 0);
            cycle();
        end
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        cycle();
        cycle();
        cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
